// File: rtl/rht_rollback_walker.sv
// Rename-history rollback walker: replays squashed RHT entries youngest-first into the RAT.
// Optional walk_cnt restore counter is enabled by defining RHT_WALK_CNT_EN.
module rht_rollback_walker #(
  parameter int RHT_DEPTH    = 128,
  parameter int L_ADDR_WIDTH = 5,
  parameter int P_ADDR_WIDTH = 8,
  parameter int TW           = $clog2(RHT_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_valid,
  input  logic [TW-1:0]           flush_id,
  output logic                    flush_ready,
  input  logic [TW-1:0]           rht_tail,
  output logic [TW-1:0]           rd_id,
  input  logic [L_ADDR_WIDTH-1:0] rd_Ldst,
  input  logic [P_ADDR_WIDTH-1:0] rd_Pdst,
  output logic                    restore_valid,
  output logic [L_ADDR_WIDTH-1:0] restore_Ldst,
  output logic [P_ADDR_WIDTH-1:0] restore_Pdst,
  output logic                    set_ptr,
  output logic [TW-1:0]           new_pointer,
  output logic                    busy
`ifdef RHT_WALK_CNT_EN
  ,
  output logic [TW:0]             walk_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WALK   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [TW-1:0] LAST = TW'(RHT_DEPTH - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] cur_q, cur_d;
  logic [TW-1:0] tgt_q, tgt_d;
  logic          accept;

  // Ring decrement; depth need not be a power of two
  function automatic logic [TW-1:0] dec(
    input logic [TW-1:0] v
  );
    return (v == '0) ? LAST : v - 1'b1;
  endfunction

  assign accept = flush_valid && (state_q == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_q   <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    unique case (state_q)
      IDLE: begin
        if (flush_valid) begin
          tgt_d   = flush_id;
          cur_d   = dec(rht_tail);
          state_d = (rht_tail == flush_id) ? COMMIT : WALK;
        end
      end
      WALK: begin
        if (cur_q == tgt_q) begin
          state_d = COMMIT;
        end else begin
          cur_d = dec(cur_q);
        end
      end
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign flush_ready   = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign restore_valid = (state_q == WALK);
  assign set_ptr       = (state_q == COMMIT);
  assign rd_id         = cur_q;
  assign new_pointer   = tgt_q;
  assign restore_Ldst  = rd_Ldst;
  assign restore_Pdst  = rd_Pdst;

`ifdef RHT_WALK_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      walk_cnt <= '0;
    end else if (accept) begin
      walk_cnt <= '0;
    end else if (state_q == WALK) begin
      walk_cnt <= walk_cnt + 1'b1;
    end
  end
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_rht_rollback_walker.sv
// Randomized/directed bench for rht_rollback_walker.
// Checks restore order, RAT outcome, commit timing and reset abort.
module tb_rht_rollback_walker;

  localparam int D = 128;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush_valid;
  logic [6:0] flush_id;
  logic       flush_ready;
  logic [6:0] rht_tail;
  logic [6:0] rd_id;
  logic [4:0] rd_Ldst;
  logic [7:0] rd_Pdst;
  logic       restore_valid;
  logic [4:0] restore_Ldst;
  logic [7:0] restore_Pdst;
  logic       set_ptr;
  logic [6:0] new_pointer;
  logic       busy;
`ifdef RHT_WALK_CNT_EN
  logic [7:0] walk_cnt;
`endif

  logic       fv6;
  logic [2:0] fid6;
  logic       rdy6;
  logic [2:0] tail6;
  logic [2:0] rd6;
  logic [4:0] rl6;
  logic [7:0] rp6;
  logic       rv6;
  logic [4:0] ol6;
  logic [7:0] op6;
  logic       sp6;
  logic [2:0] np6;
  logic       busy6;
`ifdef RHT_WALK_CNT_EN
  logic [3:0] wc6;
`endif

  logic [4:0] mem_l [D];
  logic [7:0] mem_p [D];
  logic [7:0] rat   [32];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign rd_Ldst = mem_l[rd_id];
  assign rd_Pdst = mem_p[rd_id];
  assign rl6     = mem_l[rd6];
  assign rp6     = mem_p[rd6];

  rht_rollback_walker u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_valid  (flush_valid),
    .flush_id     (flush_id),
    .flush_ready  (flush_ready),
    .rht_tail     (rht_tail),
    .rd_id        (rd_id),
    .rd_Ldst      (rd_Ldst),
    .rd_Pdst      (rd_Pdst),
    .restore_valid(restore_valid),
    .restore_Ldst (restore_Ldst),
    .restore_Pdst (restore_Pdst),
    .set_ptr      (set_ptr),
    .new_pointer  (new_pointer),
    .busy         (busy)
`ifdef RHT_WALK_CNT_EN
    ,
    .walk_cnt     (walk_cnt)
`endif
  );

  rht_rollback_walker #(.RHT_DEPTH(6)) u_d6 (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_valid  (fv6),
    .flush_id     (fid6),
    .flush_ready  (rdy6),
    .rht_tail     (tail6),
    .rd_id        (rd6),
    .rd_Ldst      (rl6),
    .rd_Pdst      (rp6),
    .restore_valid(rv6),
    .restore_Ldst (ol6),
    .restore_Pdst (op6),
    .set_ptr      (sp6),
    .new_pointer  (np6),
    .busy         (busy6)
`ifdef RHT_WALK_CNT_EN
    ,
    .walk_cnt     (wc6)
`endif
  );

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush(
    input int tail,
    input int fid,
    input bit hold
  );
    int         n;
    int         id;
    int         nbad;
    logic [7:0] exp_rat [32];
    bit         seen    [32];
    n = (tail - fid + D) % D;
    for (int l = 0; l < 32; l++) begin
      exp_rat[l] = rat[l];
      seen[l]    = 1'b0;
    end
    // Oldest squashed mapping is the one that must survive
    for (int j = 0; j < n; j++) begin
      id = (fid + j) % D;
      if (!seen[mem_l[id]]) begin
        exp_rat[mem_l[id]] = mem_p[id];
        seen[mem_l[id]]    = 1'b1;
      end
    end
    rht_tail    = 7'(tail);
    flush_id    = 7'(fid);
    flush_valid = 1'b1;
    #1;
    check("ready_pre", flush_ready, 1);
    step();
    if (!hold) flush_valid = 1'b0;
    for (int k = 1; k <= n; k++) begin
      rht_tail = 7'($urandom);
      flush_id = 7'($urandom);
      id = (tail - k + D) % D;
      check("walk_rv", restore_valid, 1);
      check("walk_rd", rd_id, id);
      check("walk_l", restore_Ldst, mem_l[id]);
      check("walk_p", restore_Pdst, mem_p[id]);
      check("walk_busy", {busy, flush_ready, set_ptr}, 3'b100);
      if (restore_valid) rat[restore_Ldst] = restore_Pdst;
      step();
    end
    check("cm_set", set_ptr, 1);
    check("cm_np", new_pointer, fid);
    check("cm_st", {busy, flush_ready, restore_valid}, 3'b100);
    step();
    check("idle_st", {busy, flush_ready, set_ptr, restore_valid}, 4'b0100);
    flush_valid = 1'b0;
`ifdef RHT_WALK_CNT_EN
    check("walk_cnt", walk_cnt, n);
`endif
    nbad = 0;
    for (int l = 0; l < 32; l++) begin
      if (rat[l] !== exp_rat[l]) nbad++;
    end
    check("rat", nbad, 0);
  endtask

  initial begin
    int   t;
    int   f;
    logic stray;
    for (int i = 0; i < D; i++) begin
      mem_l[i] = 5'($urandom);
      mem_p[i] = 8'($urandom);
    end
    for (int l = 0; l < 32; l++) rat[l] = 8'(l);
    rst_n       = 1'b0;
    flush_valid = 1'b0;
    flush_id    = '0;
    rht_tail    = '0;
    fv6         = 1'b0;
    fid6        = '0;
    tail6       = '0;
    #12;
    check("rst_st", {busy, flush_ready, set_ptr, restore_valid}, 4'b0100);
    check("rst_ptr", {rd_id, new_pointer}, 0);
    step();
    rst_n = 1'b1;
    step();

    do_flush(10, 7, 1'b0);
    do_flush(2, 126, 1'b0);
    do_flush(40, 40, 1'b0);
    do_flush(0, 0, 1'b0);
    do_flush(20, 15, 1'b1);
    do_flush(5, 6, 1'b0);
    for (int r = 0; r < 8; r++) begin
      t = int'($urandom_range(0, D - 1));
      f = int'($urandom_range(0, D - 1));
      do_flush(t, f, r[0]);
    end

    // Depth-6 ring: tail 0 wraps to 5
    tail6 = 3'd0;
    fid6  = 3'd4;
    fv6   = 1'b1;
    #1;
    check("d6_rdy", rdy6, 1);
    step();
    fv6 = 1'b0;
    check("d6_rd0", {rv6, rd6}, {1'b1, 3'd5});
    check("d6_l0", ol6, mem_l[5]);
    step();
    check("d6_rd1", {rv6, rd6}, {1'b1, 3'd4});
    step();
    check("d6_cm", {sp6, np6, rv6}, {1'b1, 3'd4, 1'b0});
    step();
    check("d6_idle", {rdy6, sp6, busy6}, 3'b100);

    // Reset in the middle of a six-entry walk
    rht_tail    = 7'd20;
    flush_id    = 7'd14;
    flush_valid = 1'b1;
    step();
    flush_valid = 1'b0;
    step();
    check("pre_abort", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_st", {busy, flush_ready, set_ptr, restore_valid}, 4'b0100);
    check("abort_ptr", {rd_id, new_pointer}, 0);
    step();
    rst_n = 1'b1;
    stray = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (set_ptr || restore_valid || busy) stray = 1'b1;
    end
    check("abort_quiet", stray, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
